// File: rtl/mem_defs.sv
// Shared definitions for the memory arbiter: FSM encodings, port ids, sizes.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package mem_defs;

  // Sequencer state encoding. Kept as plain 2-bit constants so the encoding
  // matches the legacy decode used by the surrounding pipeline.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  // Requester ids. last_gnt resets to PORT_IF so load/store wins the first tie.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Default backing array size in bytes (1 KiB, 32-bit words).
  localparam int unsigned MEM_BYTES_DEF = 1024;

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin picker between fetch and load/store with a last-grant register.
// Latency: combinational grant; last_gnt updates on the edge that takes the grant.
// Backpressure: grants only while gnt_en_i is high; requests are simply held by the requesters.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   req_if_i     fetch port requesting
//   req_ls_i     load/store port requesting
//   gnt_en_i     sequencer can accept a grant this cycle (IDLE)
//   gnt_vld_o    a grant is taken this cycle
//   gnt_port_o   granted port id (PORT_IF / PORT_LS), meaningful when gnt_vld_o
module rr_arb2
  import mem_defs::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_if_i,
  input  logic req_ls_i,
  input  logic gnt_en_i,
  output logic gnt_vld_o,
  output logic gnt_port_o
);

  logic last_gnt_q;
  logic last_gnt_d;

  always_comb begin
    gnt_vld_o  = gnt_en_i && (req_if_i || req_ls_i);
    gnt_port_o = PORT_IF;
    if (req_if_i && req_ls_i) begin
      // Tie: favour whichever port did not win last time.
      gnt_port_o = (last_gnt_q == PORT_IF) ? PORT_LS : PORT_IF;
    end else if (req_ls_i) begin
      gnt_port_o = PORT_LS;
    end

    // Every grant moves the pointer, so a lone requester also yields the next
    // tie to the other port.
    last_gnt_d = gnt_vld_o ? gnt_port_o : last_gnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= PORT_IF;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter and sequencer in front of the word Memory.
// Latency: request sampled in IDLE at N -> ack in N+2 (valid) or N+1 (address error); 3 cycles/txn.
// Backpressure: requesters hold req until their one-cycle ack; one transaction in flight at a time.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   if_req/if_addr                   fetch request (read-only)
//   if_ack/if_rdata/if_err           fetch completion pulse, data, error flag
//   ls_req/ls_we/ls_addr/ls_wdata    load/store request
//   ls_ack/ls_rdata/ls_err           load/store completion pulse, data, error flag
//   mem_addr/mem_in/mem_out          Memory address, write data, read data
//   mem_read_sig/mem_wrt_sig         one-cycle Memory strobes (ACCESS only)
//   busy                             sequencer not in IDLE
module mem_arbiter
  import mem_defs::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  // load/store port
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_err,
  // memory side
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_read_sig,
  output logic          mem_wrt_sig,
  input  logic [DW-1:0] mem_out,
  // status
  output logic          busy
);

  // Highest legal word address; the compare below is unsigned over all AW bits
  // so huge addresses never wrap into range.
  localparam logic [AW-1:0] LAST_WORD = AW'(MEM_BYTES - 4);

  state_t        state_q,    state_d;
  logic          port_q,     port_d;
  logic          we_q,       we_d;
  logic          err_q,      err_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_in_q,   mem_in_d;
  logic [DW-1:0] rdata_q,    rdata_d;

  logic          gnt_en;
  logic          gnt_vld;
  logic          gnt_port;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [DW-1:0] sel_wdata;
  logic          addr_bad;
  logic          in_access;
  logic          in_resp;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign gnt_en = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_if_i   (if_req),
    .req_ls_i   (ls_req),
    .gnt_en_i   (gnt_en),
    .gnt_vld_o  (gnt_vld),
    .gnt_port_o (gnt_port)
  );

  // Mux the winning request; fetch is read-only so its we is forced low.
  always_comb begin
    sel_addr  = if_addr;
    sel_we    = 1'b0;
    sel_wdata = '0;
    if (gnt_port == PORT_LS) begin
      sel_addr  = ls_addr;
      sel_we    = ls_we;
      sel_wdata = ls_wdata;
    end
    addr_bad = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    we_d       = we_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    mem_in_d   = mem_in_q;
    rdata_d    = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          port_d  = gnt_port;
          we_d    = sel_we;
          err_d   = addr_bad;
          rdata_d = '0;
          if (addr_bad) begin
            // Rejected before the array: skip ACCESS, no strobe, and leave
            // mem_addr/mem_in untouched.
            state_d = ST_RESP;
          end else begin
            state_d    = ST_ACCESS;
            mem_addr_d = sel_addr;
            if (sel_we) begin
              mem_in_d = sel_wdata;
            end
          end
        end
      end

      ST_ACCESS: begin
        // Read data is taken on the edge leaving ACCESS; writes return zero.
        rdata_d = we_q ? '0 : mem_out;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      we_q       <= we_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_in_q   <= mem_in_d;
      rdata_q    <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Strobes and acks decode straight from the state register, so an async
  // reset drops them in the same instant without waiting for a clock.
  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  assign busy         = (state_q != ST_IDLE);
  assign mem_addr     = mem_addr_q;
  assign mem_in       = mem_in_q;
  assign mem_read_sig = in_access && !we_q;
  assign mem_wrt_sig  = in_access &&  we_q;

  always_comb begin
    if_ack   = in_resp && (port_q == PORT_IF);
    ls_ack   = in_resp && (port_q == PORT_LS);
    if_err   = if_ack && err_q;
    ls_err   = ls_ack && err_q;
    if_rdata = (if_ack && !err_q) ? rdata_q : '0;
    ls_rdata = (ls_ack && !err_q) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_defs::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        if_ack, if_err, ls_ack, ls_err;
  logic [31:0] if_rdata, ls_rdata;
  logic [31:0] mem_addr, mem_in, mem_out;
  logic        mem_read_sig, mem_wrt_sig, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BYTES(1024), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_read_sig(mem_read_sig),
    .mem_wrt_sig(mem_wrt_sig), .mem_out(mem_out), .busy(busy)
  );

  // Simple behavioural Memory: async read, write on posedge under strobe.
  logic [31:0] mem_model [0:255];
  assign mem_out = mem_model[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_wrt_sig) mem_model[mem_addr[9:2]] <= mem_in;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int wr_cnt  = 0;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe sanity plus scoreboard pop on every ack.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read_sig) rd_cnt++;
      if (mem_wrt_sig)  wr_cnt++;
      if (mem_read_sig || mem_wrt_sig)
        check("strobe_exclusive", 64'({mem_read_sig, mem_wrt_sig} == 2'b11), 64'(0));
      if (if_ack || ls_ack) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: if_ack=%0b ls_ack=%0b at cycle %0d, expected no ack",
                   if_ack, ls_ack, cyc);
        end else begin
          e = sb.pop_front();
          check("ack_port", 64'({if_ack, ls_ack}), 64'((e.port == PORT_LS) ? 2'b01 : 2'b10));
          check("ack_cycle", 64'(cyc), 64'(e.cyc));
          if (e.port == PORT_LS) begin
            check("ls_err", 64'(ls_err), 64'(e.err));
            check("ls_rdata", 64'(ls_rdata), 64'(e.rdata));
            check("if_quiet", 64'({if_ack, if_err, if_rdata}), 64'(0));
          end else begin
            check("if_err", 64'(if_err), 64'(e.err));
            check("if_rdata", 64'(if_rdata), 64'(e.rdata));
            check("ls_quiet", 64'({ls_ack, ls_err, ls_rdata}), 64'(0));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic port, input string nm);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if ((port == PORT_LS) ? ls_ack : if_ack) found = 1'b1;
    end
    check({nm, "_ack_seen"}, 64'(found), 64'(1));
    tick();
  endtask

  // Issue one request from a quiet IDLE cycle and hold it until its ack.
  task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic exp_err,
                       input logic [31:0] exp_rd, input string nm);
    exp_t x;
    x.port  = port;
    x.err   = exp_err;
    x.rdata = exp_rd;
    x.cyc   = cyc + (exp_err ? 1 : 2);
    sb.push_back(x);
    if (port == PORT_LS) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    wait_ack(port, nm);
    if (port == PORT_LS) ls_req = 1'b0;
    else                 if_req = 1'b0;
  endtask

  task automatic push_exp(input logic port, input logic err, input logic [31:0] rd, input int c);
    exp_t x;
    x.port = port; x.err = err; x.rdata = rd; x.cyc = c;
    sb.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int rd0;
    int wr0;
    for (int i = 0; i < 256; i++) mem_model[i] <= 32'h0;
    mem_model[0]   <= 32'h0000_0013;
    mem_model[1]   <= 32'h4444_4444;
    mem_model[8]   <= 32'h1111_2222;
    mem_model[255] <= 32'h0FF0_0FF0;

    // ---- reset values ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_acks_errs", 64'({if_ack, ls_ack, if_err, ls_err}), 64'(0));
    check("rst_strobes", 64'({mem_read_sig, mem_wrt_sig}), 64'(0));
    check("rst_mem_addr_in", 64'({mem_addr, mem_in}), 64'(0));
    check("rst_rdata", 64'({if_rdata, ls_rdata}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // ---- contention straight out of reset: LS, IF, LS, IF every 3 cycles ----
    rst_n = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    t0 = cyc;
    push_exp(PORT_LS, 1'b0, 32'h1111_2222, t0 + 2);
    push_exp(PORT_IF, 1'b0, 32'h0000_0013, t0 + 5);
    push_exp(PORT_LS, 1'b0, 32'h1111_2222, t0 + 8);
    push_exp(PORT_IF, 1'b0, 32'h0000_0013, t0 + 11);
    repeat (12) tick();
    ls_req = 1'b0; if_req = 1'b0;
    tick(); tick();
    check("contention_drained", 64'(sb.size()), 64'(0));
    check("contention_idle", 64'(busy), 64'(0));

    // ---- store then load ----
    wr0 = wr_cnt;
    issue(PORT_LS, 1'b1, 32'd8, 32'hDEAD_BEEF, 1'b0, 32'h0, "store8");
    check("store8_wr_pulses", 64'(wr_cnt - wr0), 64'(1));
    check("store8_mem", 64'(mem_model[2]), 64'(32'hDEAD_BEEF));
    issue(PORT_LS, 1'b0, 32'd8, 32'h0, 1'b0, 32'hDEAD_BEEF, "load8");

    // ---- fetch ----
    rd0 = rd_cnt;
    issue(PORT_IF, 1'b0, 32'd0, 32'h0, 1'b0, 32'h0000_0013, "fetch0");
    check("fetch0_rd_pulses", 64'(rd_cnt - rd0), 64'(1));

    // ---- address errors and boundary ----
    wr0 = wr_cnt;
    issue(PORT_LS, 1'b1, 32'd6, 32'h1234_5678, 1'b1, 32'h0, "st_misaligned");
    check("st_misaligned_no_wr", 64'(wr_cnt - wr0), 64'(0));
    check("st_misaligned_mem", 64'(mem_model[1]), 64'(32'h4444_4444));
    issue(PORT_IF, 1'b0, 32'd1020, 32'h0, 1'b0, 32'h0FF0_0FF0, "fetch1020");
    issue(PORT_LS, 1'b1, 32'd1020, 32'hABCD_0123, 1'b0, 32'h0, "store1020");
    issue(PORT_IF, 1'b0, 32'd1021, 32'h0, 1'b1, 32'h0, "fetch1021");
    check("mem_addr_held", 64'(mem_addr), 64'(1020));
    issue(PORT_IF, 1'b0, 32'd1024, 32'h0, 1'b1, 32'h0, "fetch1024");
    issue(PORT_LS, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, "load_huge");
    issue(PORT_LS, 1'b0, 32'd1020, 32'h0, 1'b0, 32'hABCD_0123, "load1020");

    // ---- request withdrawal, fetch queued behind ----
    t0 = cyc;
    push_exp(PORT_LS, 1'b0, 32'hDEAD_BEEF, t0 + 2);
    push_exp(PORT_IF, 1'b0, 32'h0000_0013, t0 + 5);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd8;
    tick();
    ls_req = 1'b0;
    if_req = 1'b1; if_addr = 32'd0;
    wait_ack(PORT_IF, "withdraw_fetch");
    if_req = 1'b0;
    tick();
    check("withdraw_drained", 64'(sb.size()), 64'(0));

    // ---- reset in the middle of a write ACCESS ----
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hCAFE_0000;
    tick();
    check("midrst_wr_before", 64'(mem_wrt_sig), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_strobe_drop", 64'({mem_read_sig, mem_wrt_sig}), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    ls_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("midrst_mem", 64'(mem_model[16]), 64'(0));
    check("postrst_outputs", 64'({busy, if_ack, ls_ack, if_err, ls_err, mem_read_sig, mem_wrt_sig}), 64'(0));
    check("postrst_data", 64'({mem_addr, mem_in}), 64'(0));
    check("postrst_rdata", 64'({if_rdata, ls_rdata}), 64'(0));
    check("postrst_no_pending", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and sequencer in front of the 1 KiB byte-addressed, 32-bit-word Memory block.
- Shares the single Memory between an instruction-fetch port (read-only) and a load/store port (read/write).
- Serialises accesses with round-robin arbitration.
- Generates the one-cycle mem_read_sig / mem_wrt_sig strobes.
- Rejects misaligned or out-of-range addresses before they reach the array.
- Sits between the fetch/execute stages and Memory.

Parameters:
MEM_BYTES, 1024, size of the backing array in bytes; legal word addresses are 0..MEM_BYTES-4.
AW, 32, address width.
DW, 32, data width.

Ports:
clk  in  1  system clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
if_req  in  1  fetch request; held until if_ack.
if_addr  in  AW  fetch byte address; stable while if_req is high.
if_ack  out  1  one-cycle completion pulse to fetch.
if_rdata  out  DW  fetch read data; valid while if_ack is high.
if_err  out  1  fetch error flag; valid while if_ack is high.
ls_req  in  1  load/store request; held until ls_ack.
ls_we  in  1  1 = write, 0 = read.
ls_addr  in  AW  load/store byte address.
ls_wdata  in  DW  store data.
ls_ack  out  1  one-cycle completion pulse to load/store.
ls_rdata  out  DW  load read data; valid while ls_ack is high.
ls_err  out  1  load/store error flag; valid while ls_ack is high.
mem_addr  out  AW  address to Memory.
mem_in  out  DW  write data to Memory.
mem_read_sig  out  1  read strobe to Memory.
mem_wrt_sig  out  1  write strobe to Memory.
mem_out  in  DW  read data from Memory.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE.
  - All ack, err and strobe outputs = 0.
  - mem_addr, mem_in, if_rdata, ls_rdata = 0.
  - Round-robin pointer last_gnt = IF, so load/store wins the first tie.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and any strobe drops immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port that is not last_gnt, then update last_gnt.
  - On grant, latch port id, address, we (0 for fetch) and wdata.
  - Address check: addr[1:0] != 0 or addr > MEM_BYTES-4 → go to RESP with err_pend = 1 and no memory strobe.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched address.
  - Read: mem_read_sig = 1.
  - Write: mem_wrt_sig = 1 and mem_in = wdata.
  - On the exiting edge, capture mem_out into the read-data register. The captured value is don't-care for writes; drive 0.
  - Next state: RESP.
- RESP (exactly 1 cycle):
  - Assert the granted port's ack.
  - Drive that port's rdata: captured data, or 0 if err.
  - Drive that port's err.
  - The non-granted port's outputs stay 0.
  - Next state: IDLE.
- Strobes: mem_read_sig and mem_wrt_sig are never high together and are high only in ACCESS. mem_addr holds its last value outside ACCESS.
- Latency:
  - Request sampled in IDLE at cycle N → ack during cycle N+2 for a valid access.
  - Error access → ack during N+1.
  - Back-to-back throughput: one transaction per 3 cycles.
- Requester rules:
  - Deassert req on the edge that ends the ack cycle.
  - req still high in the following IDLE cycle is a new request.
  - If req drops mid-transaction, the transaction still completes and ack still pulses.
- Starvation: with both ports continuously requesting, grants strictly alternate.
- Arithmetic: address compare is unsigned and full AW width; no wrap-around.

Decomposition:
- Shared package/header mem_defs: state encodings (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2), port ids (PORT_IF = 1'b0, PORT_LS = 1'b1), MEM_BYTES default.
- One natural sub-module, rr_arb2: 2-way round-robin picker with a last_gnt register and a grant-enable input.

Test Plan:
1. Reset/idle: assert rst_n low mid-ACCESS of a write → strobes drop at once, no ack; after release, busy = 0 and all outputs 0.
2. Store then load: ls write addr 8, data 0xDEADBEEF → mem_wrt_sig high for exactly 1 cycle, ls_ack at N+2, ls_err = 0; ls read addr 8 → ls_rdata = 0xDEADBEEF at N+2.
3. Fetch: preload addr 0 = 0x00000013; if_req addr 0 → mem_read_sig 1 cycle, if_ack at N+2 with if_rdata = 0x00000013; ls outputs stay 0.
4. Contention: both ports request continuously from reset → grant order LS, IF, LS, IF; acks spaced 3 cycles apart; no strobe overlap.
5. Errors:
   - ls write addr 6 (misaligned) → ls_ack at N+1, ls_err = 1, no mem_wrt_sig, memory unchanged.
   - if_req addr 1021 (> 1020) → if_err = 1, if_rdata = 0.
   - Boundary: addr 1020 → valid access, err = 0.
6. Request withdrawal: ls_req drops the cycle after grant → transaction completes and ls_ack still pulses; a fetch queued behind it is served next.
